// File: rtl/apb_ic_pkg.sv
// Shared types and default bus widths for the APB interconnect request path.
package apb_ic_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Per-cycle FIFO operation, bit 0 = push accepted, bit 1 = pop accepted
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PUSH = 2'b01,
        POP  = 2'b10,
        BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/apb_req_fifo_if.sv
// Handshake bundle between the APB slave, the request FIFO and the arbiter.
// Error outputs exist only when APB_REQ_FIFO_ERR_EN is defined.
interface apb_req_fifo_if import apb_ic_pkg::*; #(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int DEPTH  = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push_in;
    logic              push_write_in;
    logic [ADDR_W-1:0] push_addr_in;
    logic [DATA_W-1:0] push_wdata_in;
    logic              data_in_ack;
    logic              full_o;
    logic              almost_full_o;
    logic              pop_in;
    logic              empty_o;
    logic              pop_write_o;
    logic [ADDR_W-1:0] pop_addr_o;
    logic [DATA_W-1:0] pop_wdata_o;
    logic [CNT_W-1:0]  count_o;
`ifdef APB_REQ_FIFO_ERR_EN
    logic              ovf_err_o;
    logic              udf_err_o;

    modport slave (
        input  push_in, push_write_in, push_addr_in, push_wdata_in, pop_in,
        output data_in_ack, full_o, almost_full_o, empty_o,
        output pop_write_o, pop_addr_o, pop_wdata_o, count_o,
        output ovf_err_o, udf_err_o
    );
    modport master (
        output push_in, push_write_in, push_addr_in, push_wdata_in, pop_in,
        input  data_in_ack, full_o, almost_full_o, empty_o,
        input  pop_write_o, pop_addr_o, pop_wdata_o, count_o,
        input  ovf_err_o, udf_err_o
    );
`else
    modport slave (
        input  push_in, push_write_in, push_addr_in, push_wdata_in, pop_in,
        output data_in_ack, full_o, almost_full_o, empty_o,
        output pop_write_o, pop_addr_o, pop_wdata_o, count_o
    );
    modport master (
        output push_in, push_write_in, push_addr_in, push_wdata_in, pop_in,
        input  data_in_ack, full_o, almost_full_o, empty_o,
        input  pop_write_o, pop_addr_o, pop_wdata_o, count_o
    );
`endif
endinterface

// File: rtl/fifo_wrap_ptr.sv
// Pointer counter that wraps explicitly from DEPTH-1 to 0, so DEPTH need not be a power of two.
module fifo_wrap_ptr #(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_in,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_r;

    // Advance on each accepted operation, wrapping at the last slot
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (inc_in) begin
            if (ptr_r == PTR_W'(DEPTH - 1)) begin
                ptr_r <= {PTR_W{1'b0}};
            end else begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_o = ptr_r;

endmodule

// File: rtl/apb_req_fifo.sv
// Single-queue APB request FIFO with first-word-fall-through head for the arbiter.
// Optional sticky overflow/underflow flags are enabled with APB_REQ_FIFO_ERR_EN.
module apb_req_fifo import apb_ic_pkg::*; #(
    parameter int DATA_W    = APB_DATA_W,
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic           clk,
    input  logic           reset,
    apb_req_fifo_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 1 + ADDR_W + DATA_W;

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_s;
    logic [PTR_W-1:0] wr_ptr_s;
    logic [CNT_W-1:0] count_r;
    logic             full_s;
    logic             empty_s;
    logic             push_acc_s;
    logic             pop_acc_s;
    fifo_op_e         op_s;
    logic [ENT_W-1:0] head_s;
    logic [DATA_W-1:0] wdata_s;

    // Flags come from registered count only, never from push_in/pop_in
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign push_acc_s = bus.push_in & ~full_s;
    assign pop_acc_s  = bus.pop_in & ~empty_s;
    assign op_s       = fifo_op_e'({pop_acc_s, push_acc_s});
    assign wdata_s    = bus.push_write_in ? bus.push_wdata_in : {DATA_W{1'b0}};

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk    (clk),
        .reset  (reset),
        .inc_in (push_acc_s),
        .ptr_o  (wr_ptr_s)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk    (clk),
        .reset  (reset),
        .inc_in (pop_acc_s),
        .ptr_o  (rd_ptr_s)
    );

    // Entry storage; left unreset because empty_s masks stale contents
    always_ff @(posedge clk) begin
        if (push_acc_s) begin
            mem_r[wr_ptr_s] <= {bus.push_write_in, bus.push_addr_in, wdata_s};
        end
    end

    // Occupancy tracking driven by the decoded operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (op_s)
                PUSH:    count_r <= count_r + CNT_W'(1);
                POP:     count_r <= count_r - CNT_W'(1);
                IDLE:    count_r <= count_r;
                BOTH:    count_r <= count_r;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_s            = empty_s ? {ENT_W{1'b0}} : mem_r[rd_ptr_s];
    assign bus.pop_write_o   = head_s[ENT_W-1];
    assign bus.pop_addr_o    = head_s[ADDR_W+DATA_W-1:DATA_W];
    assign bus.pop_wdata_o   = head_s[DATA_W-1:0];
    assign bus.data_in_ack   = push_acc_s;
    assign bus.full_o        = full_s;
    assign bus.empty_o       = empty_s;
    assign bus.almost_full_o = (count_r >= CNT_W'(AF_THRESH));
    assign bus.count_o       = count_r;

`ifdef APB_REQ_FIFO_ERR_EN
    logic ovf_err_r;
    logic udf_err_r;

    // Sticky protocol-error flags, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_err_r <= 1'b0;
            udf_err_r <= 1'b0;
        end else begin
            ovf_err_r <= ovf_err_r | (bus.push_in & full_s);
            udf_err_r <= udf_err_r | (bus.pop_in & empty_s);
        end
    end

    assign bus.ovf_err_o = ovf_err_r;
    assign bus.udf_err_o = udf_err_r;
`endif

endmodule

// File: tb/tb_apb_req_fifo.sv
// Directed self-checking bench for apb_req_fifo (DEPTH 8 and non-power-of-two DEPTH 5).
module tb_apb_req_fifo;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   fails;

    apb_req_fifo_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(8)) bus ();
    apb_req_fifo_if #(.ADDR_W(32), .DATA_W(32), .DEPTH(5)) bus5 ();

    apb_req_fifo #(.DATA_W(32), .ADDR_W(32), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    apb_req_fifo #(.DATA_W(32), .ADDR_W(32), .DEPTH(5), .AF_THRESH(4)) dut5 (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus5.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic push, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic pop);
        bus.push_in       = push;
        bus.push_write_in = wr;
        bus.push_addr_in  = addr;
        bus.push_wdata_in = wdata;
        bus.pop_in        = pop;
    endtask

    task automatic drive5(input logic push, input logic [31:0] addr, input logic pop);
        bus5.push_in       = push;
        bus5.push_write_in = 1'b1;
        bus5.push_addr_in  = addr;
        bus5.push_wdata_in = addr ^ 32'hFFFF_0000;
        bus5.pop_in        = pop;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        drive5(1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.empty_o !== 1'b1 || bus.count_o !== 4'd0 || bus.full_o !== 1'b0 ||
            bus.almost_full_o !== 1'b0 || bus.data_in_ack !== 1'b0 || bus.pop_addr_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: empty=%b count=%0d full=%b af=%b ack=%b addr=%h, want 1 0 0 0 0 0",
                     bus.empty_o, bus.count_o, bus.full_o, bus.almost_full_o, bus.data_in_ack, bus.pop_addr_o);
        end
        rst_n = 1'b1;
`ifdef APB_REQ_FIFO_ERR_EN
        tests_run++;
        if (bus.udf_err_o !== 1'b0) begin
            fails++;
            $display("FAIL udf_before_pop: got %b want 0", bus.udf_err_o);
        end
`endif
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            tests_run++;
            if (bus.empty_o !== 1'b1 || bus.count_o !== 4'd0 || bus.pop_addr_o !== 32'h0) begin
                fails++;
                $display("FAIL empty_pop[%0d]: empty=%b count=%0d addr=%h, want 1 0 0",
                         k, bus.empty_o, bus.count_o, bus.pop_addr_o);
            end
`ifdef APB_REQ_FIFO_ERR_EN
            tests_run++;
            if (bus.udf_err_o !== 1'b1) begin
                fails++;
                $display("FAIL udf_sticky[%0d]: got %b want 1", k, bus.udf_err_o);
            end
`endif
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_fill();
        logic exp_af;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
            #1;
            tests_run++;
            if (bus.data_in_ack !== 1'b1) begin
                fails++;
                $display("FAIL fill_ack[%0d]: got %b want 1", i, bus.data_in_ack);
            end
            step();
            exp_af = ((i + 1) >= 6);
            tests_run++;
            if (bus.count_o !== 4'(i + 1) || bus.almost_full_o !== exp_af ||
                bus.full_o !== ((i + 1) == 8) || bus.pop_addr_o !== 32'h100) begin
                fails++;
                $display("FAIL fill_status[%0d]: count=%0d af=%b full=%b head=%h, want %0d %b %b 00000100",
                         i, bus.count_o, bus.almost_full_o, bus.full_o, bus.pop_addr_o,
                         i + 1, exp_af, (i + 1) == 8);
            end
        end
        drive(1'b1, 1'b1, 32'h999, 32'hEE, 1'b0);
        #1;
        tests_run++;
        if (bus.data_in_ack !== 1'b0) begin
            fails++;
            $display("FAIL full_ack: got %b want 0", bus.data_in_ack);
        end
        step();
        tests_run++;
        if (bus.count_o !== 4'd8 || bus.full_o !== 1'b1) begin
            fails++;
            $display("FAIL full_hold: count=%0d full=%b, want 8 1", bus.count_o, bus.full_o);
        end
`ifdef APB_REQ_FIFO_ERR_EN
        tests_run++;
        if (bus.ovf_err_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: got %b want 1", bus.ovf_err_o);
        end
`endif
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_drain_wrap();
        logic [31:0] exp_addr [8];
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            #1;
            tests_run++;
            if (bus.pop_addr_o !== 32'h100 + 32'(4 * i) || bus.pop_write_o !== 1'b1 ||
                bus.pop_wdata_o !== 32'hA0 + 32'(i)) begin
                fails++;
                $display("FAIL drain5[%0d]: addr=%h wr=%b wdata=%h, want %h 1 %h", i,
                         bus.pop_addr_o, bus.pop_write_o, bus.pop_wdata_o,
                         32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            end
            step();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 32'h200 + 32'(i), 32'hDEAD_BEEF, 1'b0);
            step();
        end
        tests_run++;
        if (bus.count_o !== 4'd8) begin
            fails++;
            $display("FAIL refill_count: got %0d want 8", bus.count_o);
        end
        exp_addr = '{32'h114, 32'h118, 32'h11C, 32'h200, 32'h201, 32'h202, 32'h203, 32'h204};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            #1;
            tests_run++;
            if (bus.pop_addr_o !== exp_addr[i] || bus.pop_write_o !== (i < 3) ||
                bus.pop_wdata_o !== ((i < 3) ? 32'hA5 + 32'(i) : 32'h0)) begin
                fails++;
                $display("FAIL wrap_order[%0d]: addr=%h wr=%b wdata=%h, want %h %b %h", i,
                         bus.pop_addr_o, bus.pop_write_o, bus.pop_wdata_o, exp_addr[i], i < 3,
                         (i < 3) ? 32'hA5 + 32'(i) : 32'h0);
            end
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (bus.empty_o !== 1'b1 || bus.count_o !== 4'd0) begin
            fails++;
            $display("FAIL drained_empty: empty=%b count=%0d, want 1 0", bus.empty_o, bus.count_o);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h300 + 32'(i), 32'h0, 1'b0);
            step();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b1, 32'h303 + 32'(k), 32'h0, 1'b1);
            #1;
            tests_run++;
            if (bus.pop_addr_o !== 32'h300 + 32'(k)) begin
                fails++;
                $display("FAIL both_order[%0d]: got %h want %h", k, bus.pop_addr_o, 32'h300 + 32'(k));
            end
            step();
            tests_run++;
            if (bus.count_o !== 4'd3) begin
                fails++;
                $display("FAIL both_count[%0d]: got %0d want 3", k, bus.count_o);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h30D + 32'(i), 32'h0, 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 32'h3FF, 32'h0, 1'b1);
        #1;
        tests_run++;
        if (bus.data_in_ack !== 1'b0 || bus.pop_addr_o !== 32'h30A) begin
            fails++;
            $display("FAIL full_both: ack=%b head=%h, want 0 0000030a", bus.data_in_ack, bus.pop_addr_o);
        end
        step();
        tests_run++;
        if (bus.count_o !== 4'd7 || bus.pop_addr_o !== 32'h30B) begin
            fails++;
            $display("FAIL full_both_after: count=%0d head=%h, want 7 0000030b", bus.count_o, bus.pop_addr_o);
        end
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            #1;
            tests_run++;
            if (bus.pop_addr_o !== 32'h30B + 32'(i)) begin
                fails++;
                $display("FAIL full_both_drain[%0d]: got %h want %h", i, bus.pop_addr_o, 32'h30B + 32'(i));
            end
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (bus.empty_o !== 1'b1) begin
            fails++;
            $display("FAIL simul_empty: got %b want 1", bus.empty_o);
        end
    endtask

    task automatic test_empty_push_pop();
        drive(1'b1, 1'b1, 32'h55, 32'h5A5A, 1'b1);
        #1;
        tests_run++;
        if (bus.data_in_ack !== 1'b1) begin
            fails++;
            $display("FAIL empty_both_ack: got %b want 1", bus.data_in_ack);
        end
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (bus.count_o !== 4'd1 || bus.pop_addr_o !== 32'h55 || bus.pop_wdata_o !== 32'h5A5A) begin
            fails++;
            $display("FAIL empty_both: count=%0d addr=%h wdata=%h, want 1 00000055 00005a5a",
                     bus.count_o, bus.pop_addr_o, bus.pop_wdata_o);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 32'h600 + 32'(i), 32'h1, 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (bus.count_o !== 4'd5) begin
            fails++;
            $display("FAIL pre_reset_count: got %0d want 5", bus.count_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.empty_o !== 1'b1 || bus.count_o !== 4'd0 || bus.pop_addr_o !== 32'h0) begin
            fails++;
            $display("FAIL async_reset: empty=%b count=%0d addr=%h, want 1 0 0",
                     bus.empty_o, bus.count_o, bus.pop_addr_o);
        end
        step();
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 32'h77, 32'h7, 1'b0);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tests_run++;
        if (bus.count_o !== 4'd1 || bus.pop_addr_o !== 32'h77) begin
            fails++;
            $display("FAIL post_reset_use: count=%0d head=%h, want 1 00000077", bus.count_o, bus.pop_addr_o);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_np2_depth();
        for (int i = 0; i < 4; i++) begin
            drive5(1'b1, 32'h400 + 32'(i), 1'b0);
            step();
        end
        drive5(1'b0, 32'h0, 1'b0);
        tests_run++;
        if (bus5.count_o !== 3'd4 || bus5.almost_full_o !== 1'b1 || bus5.full_o !== 1'b0) begin
            fails++;
            $display("FAIL np2_status: count=%0d af=%b full=%b, want 4 1 0",
                     bus5.count_o, bus5.almost_full_o, bus5.full_o);
        end
        for (int k = 4; k < 12; k++) begin
            drive5(1'b1, 32'h400 + 32'(k), 1'b1);
            #1;
            tests_run++;
            if (bus5.pop_addr_o !== 32'h400 + 32'(k - 4) ||
                bus5.pop_wdata_o !== ((32'h400 + 32'(k - 4)) ^ 32'hFFFF_0000)) begin
                fails++;
                $display("FAIL np2_order[%0d]: addr=%h wdata=%h, want %h", k,
                         bus5.pop_addr_o, bus5.pop_wdata_o, 32'h400 + 32'(k - 4));
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive5(1'b0, 32'h0, 1'b1);
            #1;
            tests_run++;
            if (bus5.pop_addr_o !== 32'h408 + 32'(i)) begin
                fails++;
                $display("FAIL np2_drain[%0d]: got %h want %h", i, bus5.pop_addr_o, 32'h408 + 32'(i));
            end
            step();
        end
        drive5(1'b0, 32'h0, 1'b0);
        tests_run++;
        if (bus5.empty_o !== 1'b1 || bus5.count_o !== 3'd0) begin
            fails++;
            $display("FAIL np2_empty: empty=%b count=%0d, want 1 0", bus5.empty_o, bus5.count_o);
        end
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        test_reset();
        test_fill();
        test_drain_wrap();
        test_simultaneous();
        test_empty_push_pop();
        test_async_reset();
        test_np2_depth();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/apb_req_fifo.md
Name: apb_req_fifo

Overview:
- Parametrised request FIFO between an APB slave port and the round-robin arbiter.
- Each entry holds one complete transfer: direction, address and write data. This replaces the split address and write-data queues, so reads and writes stay ordered in a single queue.
- First-word-fall-through (FWFT) head presentation to the arbiter.
- Exact full, empty, almost-full and occupancy status.

Parameters:
- DATA_W, 32, width of write data.
- ADDR_W, 32, width of address.
- DEPTH, 8, number of entries; any value >= 2, not restricted to powers of two.
- AF_THRESH, DEPTH-2, almost_full_o asserts when count >= AF_THRESH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous reset, active-low.
- push_in  in  1  slave requests an enqueue.
- push_write_in  in  1  1 = write transfer, 0 = read transfer.
- push_addr_in  in  ADDR_W  transfer address.
- push_wdata_in  in  DATA_W  write data; stored as zero when push_write_in = 0.
- data_in_ack  out  1  enqueue accepted this cycle.
- full_o  out  1  FIFO holds DEPTH entries.
- almost_full_o  out  1  count >= AF_THRESH.
- pop_in  in  1  arbiter consumes the head entry.
- empty_o  out  1  FIFO holds zero entries.
- pop_write_o  out  1  head entry direction.
- pop_addr_o  out  ADDR_W  head entry address.
- pop_wdata_o  out  DATA_W  head entry write data.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async assert, sync release):
  - rd_ptr, wr_ptr and count return to 0.
  - empty_o = 1; full_o, almost_full_o and data_in_ack = 0.
  - pop_* outputs = 0.
  - Storage array is not reset.
- Reset asserted mid-operation: all queued entries are discarded at once.
- Push acceptance: data_in_ack = push_in & !full_o (combinational).
  - On the clock edge, the entry is written at wr_ptr and wr_ptr advances.
  - A push while full is dropped, with no state change.
- Pop acceptance: pop_in & !empty_o.
  - rd_ptr advances on the clock edge.
  - A pop while empty is ignored.
- Pointer wrap: explicit, DEPTH-1 -> 0; no reliance on power-of-two overflow.
- Simultaneous push and pop, both accepted: both pointers advance and count is unchanged.
- Full with push and pop in the same cycle: the pop is accepted and the push is rejected, because ack depends on the registered full_o only.
- Empty with push and pop in the same cycle: the push is accepted, the pop is ignored, and count becomes 1.
- Count rules:
  - +1 on push only, -1 on pop only.
  - Never exceeds DEPTH and never underflows.
- Status flags are all registered-state derived, with no combinational path from push_in or pop_in:
  - full_o = (count == DEPTH).
  - empty_o = (count == 0).
  - almost_full_o = (count >= AF_THRESH).
- FWFT output:
  - pop_* show storage[rd_ptr] combinationally while !empty_o, and 0 when empty.
  - An entry pushed at edge N is visible on pop_* after edge N, so latency is one cycle.
  - The arbiter samples pop_* in the same cycle it asserts pop_in.
- No internal state machine. The op type {IDLE, PUSH, POP, BOTH} is decoded from the two accept signals and drives the pointer and count updates.

Optional Feature:
- Macro: APB_REQ_FIFO_ERR_EN.
- When defined, the block adds two outputs, ovf_err_o and udf_err_o, each 1 bit:
  - ovf_err_o is a sticky flag set on push_in & full_o.
  - udf_err_o is a sticky flag set on pop_in & empty_o.
  - Both are registered, set one cycle after the offending request, and cleared only by reset.
- When not defined, these ports and their logic are absent and the block behaves identically otherwise.

Decomposition:
- Package apb_ic_pkg holds:
  - enum fifo_op_e {IDLE=2'b00, PUSH=2'b01, POP=2'b10, BOTH=2'b11}.
  - Default widths APB_ADDR_W = 32 and APB_DATA_W = 32.
- Sub-module fifo_wrap_ptr, parameter DEPTH:
  - Ports clk, reset, inc_in, ptr_o.
  - Wrapping pointer counter, instantiated twice (read and write).

Test Plan:
- Reset and empty behaviour:
  - After reset, assert pop_in for 3 cycles.
  - Required: empty_o = 1, count_o = 0, pop_addr_o = 0.
  - With APB_REQ_FIFO_ERR_EN: udf_err_o = 1 from the cycle after the first pop and held.
- Fill to full:
  - Push 8 writes, addr 0x100 + 4i, wdata 0xA0+i.
  - Required: almost_full_o rises at count 6, full_o at count 8.
  - A 9th push gives data_in_ack = 0, count stays 8, and the entry is not stored.
- Drain and wrap:
  - Pop 5 entries, push 5 reads at addr 0x200+i, then pop all 8.
  - Required pop order: 0x114, 0x118, 0x11C, then 0x200..0x204 with pop_write_o = 0 and pop_wdata_o = 0.
  - Required: empty_o = 1 at the end.
- Simultaneous push and pop:
  - At count 3, push and pop together for 10 cycles.
  - Required: count_o stays 3 and entries come out in FIFO order.
  - At count 8, push and pop together: pop accepted, push rejected, count 7.
- Empty push and pop:
  - At count 0, push addr 0x55 with pop_in = 1.
  - Required: count becomes 1 and pop_addr_o = 0x55 in the next cycle.
- Async reset mid-operation:
  - At count 5, assert reset between clock edges.
  - Required: empty_o = 1 and count_o = 0 immediately, and the FIFO is usable after release.
- Non-power-of-two depth (DEPTH = 5, AF_THRESH = 4):
  - Perform 12 pushes interleaved with pops.
  - Required: the wrap from index 4 to 0 preserves order.
